btn_step_ctrl: RTL and testbench

- Front-panel input conditioner that sits directly upstream of the clock divider.
- Synchronises and debounces raw push-buttons, sampling them on a slow strobe taken from one clkdiv bit.
- Produces a pause level, which feeds the divider's SW_Pause input.
- Produces a fixed-width single-step clock pulse, which is ORed with the CPU clock while paused.

---
 rtl/btn_step_ctrl.sv | 71 +++++++
 tb/tb_btn_step_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_step_ctrl.sv
// btn_step_ctrl: debounces btn_in on tick_src rising edges into btn_level/btn_press, toggles pause and emits a fixed-width step_clk pulse
module btn_step_ctrl #(
  parameter int N_BTN      = 4,
  parameter int CNT_W      = 4,
  parameter int STABLE_CNT = 8,
  parameter int PAUSE_IDX  = 0,
  parameter int STEP_IDX   = 1,
  parameter int STEP_HOLD  = 16,
  parameter int HOLD_W     = 5,
  parameter bit PAUSE_INIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_src,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic             pause,
  output logic             step_clk
);
  typedef enum logic {IDLE, HOLD} state_t;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STABLE_CNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(STEP_HOLD - 1);
  logic [N_BTN-1:0] sync1, btn_sync;
  logic             tick_prev, tick;
  logic [CNT_W-1:0] cnt [N_BTN];
  logic [HOLD_W-1:0] hold_cnt;
  state_t           state;
  assign tick = tick_src & ~tick_prev;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= '0;
      btn_sync  <= '0;
      tick_prev <= 1'b0;
      for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
      btn_level <= '0;
      btn_press <= '0;
      pause     <= PAUSE_INIT;
      step_clk  <= 1'b0;
      hold_cnt  <= '0;
      state     <= IDLE;
    end else begin
      sync1     <= btn_in;
      btn_sync  <= sync1;
      tick_prev <= tick_src;
      for (int i = 0; i < N_BTN; i++) begin
        btn_press[i] <= 1'b0;
        if (tick) begin
          if (btn_sync[i] == btn_level[i]) cnt[i] <= '0;
          else if (cnt[i] == CNT_MAX) begin
            btn_level[i] <= btn_sync[i];
            btn_press[i] <= btn_sync[i];
            cnt[i]       <= '0;
          end else cnt[i] <= cnt[i] + 1'b1;
        end
      end
      if (btn_press[PAUSE_IDX]) pause <= ~pause;
      if (state == IDLE) begin
        if (btn_press[STEP_IDX] && pause) begin
          state    <= HOLD;
          step_clk <= 1'b1;
          hold_cnt <= HOLD_MAX;
        end
      end else if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
      else begin
        step_clk <= 1'b0;
        state    <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_btn_step_ctrl.sv
// tb_btn_step_ctrl: directed checks of debounce, press pulses, pause toggle and step pulse
module tb_btn_step_ctrl;
  logic clk = 1'b0, rst = 1'b1, tick_src = 1'b0;
  logic [3:0] btn_in = '0, btn_in2 = '0;
  logic [3:0] btn_level, btn_press, lvl2, prs2;
  logic pause, step_clk, pause2, step2;
  int total = 0, passed = 0;
  int p2 = 0, q1 = 0, s2 = 0;
  always #5 clk = ~clk;
  btn_step_ctrl dut (
    .clk(clk), .rst(rst), .tick_src(tick_src), .btn_in(btn_in),
    .btn_level(btn_level), .btn_press(btn_press), .pause(pause), .step_clk(step_clk)
  );
  btn_step_ctrl #(.STABLE_CNT(2)) dut2 (
    .clk(clk), .rst(rst), .tick_src(tick_src), .btn_in(btn_in2),
    .btn_level(lvl2), .btn_press(prs2), .pause(pause2), .step_clk(step2)
  );
  always @(posedge clk) begin
    if (btn_press[2]) p2++;
    if (prs2[1]) q1++;
    if (step2) s2++;
  end
  task automatic do_reset;
    btn_in = '0;
    btn_in2 = '0;
    rst = 1'b1;
    tick_src = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic tick_once;
    @(negedge clk) tick_src = 1'b1;
    @(negedge clk) tick_src = 1'b0;
  endtask
  task automatic ticks(input int n);
    repeat (n) tick_once();
  endtask
  task automatic settle(input logic [3:0] v);
    btn_in = v;
    repeat (3) @(negedge clk);
  endtask
  task automatic settle2(input logic [3:0] v);
    btn_in2 = v;
    repeat (3) @(negedge clk);
  endtask
  task automatic count_step(output int n, output int first, output int last);
    n = 0; first = -1; last = -1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (step_clk) begin
        n++;
        if (first < 0) first = i;
        last = i;
      end
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    btn_in = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({btn_level, btn_press, pause, step_clk} !== 10'b0)
        $display("FAIL reset_hold: got lvl=%h prs=%h pause=%b step=%b expected all 0", btn_level, btn_press, pause, step_clk);
      else passed++;
      tick_src = ~tick_src;
    end
    rst = 1'b0;
    tick_src = 1'b0;
    settle(4'hC);
    ticks(7);
    total++;
    if (btn_level !== 4'h0) $display("FAIL reset_7ticks: got %h expected 0", btn_level); else passed++;
    tick_once();
    total++;
    if (btn_level !== 4'hC || btn_press !== 4'hC)
      $display("FAIL reset_8ticks: got lvl=%h prs=%h expected C/C", btn_level, btn_press);
    else passed++;
    @(negedge clk);
    total++;
    if (btn_press !== 4'h0 || pause !== 1'b0 || step_clk !== 1'b0)
      $display("FAIL reset_after: got prs=%h pause=%b step=%b expected 0/0/0", btn_press, pause, step_clk);
    else passed++;
  endtask
  task automatic test_clean_press;
    int base;
    do_reset();
    settle(4'h4);
    ticks(7);
    total++;
    if (btn_level[2] !== 1'b0) $display("FAIL clean_early: got %b expected 0", btn_level[2]); else passed++;
    base = p2;
    tick_once();
    total++;
    if (btn_level[2] !== 1'b1 || btn_press !== 4'h4)
      $display("FAIL clean_rise: got lvl=%b prs=%h expected 1/4", btn_level[2], btn_press);
    else passed++;
    @(negedge clk);
    total++;
    if (btn_press !== 4'h0) $display("FAIL clean_pulse_width: got %h expected 0", btn_press); else passed++;
    settle(4'h0);
    ticks(7);
    total++;
    if (btn_level[2] !== 1'b1) $display("FAIL release_early: got %b expected 1", btn_level[2]); else passed++;
    tick_once();
    @(negedge clk);
    total++;
    if (btn_level[2] !== 1'b0 || p2 - base != 1)
      $display("FAIL release: got lvl=%b presses=%0d expected 0/1", btn_level[2], p2 - base);
    else passed++;
  endtask
  task automatic test_bounce;
    int base, bad;
    base = p2;
    bad = 0;
    for (int k = 0; k < 42; k++) begin
      btn_in[2] = ((k / 3) % 2 == 0);
      tick_once();
      if (btn_level[2] !== 1'b0) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL bounce_hold: got %0d high samples expected 0", bad); else passed++;
    settle(4'h4);
    ticks(7);
    total++;
    if (btn_level[2] !== 1'b0) $display("FAIL bounce_early: got %b expected 0", btn_level[2]); else passed++;
    tick_once();
    @(negedge clk);
    total++;
    if (btn_level[2] !== 1'b1 || p2 - base != 1)
      $display("FAIL bounce_final: got lvl=%b presses=%0d expected 1/1", btn_level[2], p2 - base);
    else passed++;
  endtask
  task automatic test_pause_toggle;
    do_reset();
    settle(4'h1);
    ticks(8);
    total++;
    if (btn_press[0] !== 1'b1 || pause !== 1'b0)
      $display("FAIL pause_press1: got prs=%b pause=%b expected 1/0", btn_press[0], pause);
    else passed++;
    @(negedge clk);
    total++;
    if (pause !== 1'b1) $display("FAIL pause_on: got %b expected 1", pause); else passed++;
    settle(4'h0);
    ticks(8);
    settle(4'h1);
    ticks(8);
    total++;
    if (pause !== 1'b1) $display("FAIL pause_before_toggle: got %b expected 1", pause); else passed++;
    @(negedge clk);
    total++;
    if (pause !== 1'b0) $display("FAIL pause_off: got %b expected 0", pause); else passed++;
    settle(4'h0);
    ticks(8);
    btn_in = 4'h1;
    repeat (40) @(negedge clk);
    total++;
    if (btn_level[0] !== 1'b0 || pause !== 1'b0)
      $display("FAIL no_tick: got lvl=%b pause=%b expected 0/0", btn_level[0], pause);
    else passed++;
  endtask
  task automatic test_step;
    int n, first, last;
    do_reset();
    settle(4'h1);
    ticks(8);
    @(negedge clk);
    settle(4'h0);
    ticks(8);
    settle(4'h2);
    ticks(8);
    total++;
    if (btn_press[1] !== 1'b1 || step_clk !== 1'b0 || pause !== 1'b1)
      $display("FAIL step_press: got prs=%b step=%b pause=%b expected 1/0/1", btn_press[1], step_clk, pause);
    else passed++;
    count_step(n, first, last);
    total++;
    if (n != 16 || first != 0 || last != 15)
      $display("FAIL step_width: got n=%0d first=%0d last=%0d expected 16/0/15", n, first, last);
    else passed++;
    settle(4'h0);
    ticks(8);
    settle(4'h1);
    ticks(8);
    @(negedge clk);
    total++;
    if (pause !== 1'b0) $display("FAIL step_unpause: got %b expected 0", pause); else passed++;
    settle(4'h0);
    ticks(8);
    settle(4'h2);
    ticks(8);
    total++;
    if (btn_press[1] !== 1'b1) $display("FAIL step_press_unpaused: got %b expected 1", btn_press[1]); else passed++;
    count_step(n, first, last);
    total++;
    if (n != 0) $display("FAIL step_unpaused: got %0d high cycles expected 0", n); else passed++;
  endtask
  task automatic test_simultaneous;
    int n, first, last;
    do_reset();
    settle(4'h3);
    ticks(8);
    total++;
    if (btn_press !== 4'h3) $display("FAIL simul_press: got %h expected 3", btn_press); else passed++;
    @(negedge clk);
    total++;
    if (pause !== 1'b1 || step_clk !== 1'b0)
      $display("FAIL simul_pause: got pause=%b step=%b expected 1/0", pause, step_clk);
    else passed++;
    count_step(n, first, last);
    total++;
    if (n != 0) $display("FAIL simul_step: got %0d high cycles expected 0", n); else passed++;
  endtask
  task automatic test_reset_mid_step;
    int n, first, last;
    do_reset();
    settle(4'h1);
    ticks(8);
    @(negedge clk);
    settle(4'h3);
    ticks(8);
    repeat (5) @(negedge clk);
    total++;
    if (step_clk !== 1'b1) $display("FAIL midstep_active: got %b expected 1", step_clk); else passed++;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (step_clk !== 1'b0 || pause !== 1'b0 || btn_level !== 4'h0)
      $display("FAIL midstep_reset: got step=%b pause=%b lvl=%h expected 0/0/0", step_clk, pause, btn_level);
    else passed++;
    rst = 1'b0;
    btn_in = '0;
    count_step(n, first, last);
    total++;
    if (n != 0) $display("FAIL midstep_idle: got %0d high cycles expected 0", n); else passed++;
  endtask
  task automatic test_back_to_back;
    int bq, bs;
    do_reset();
    bq = q1;
    bs = s2;
    settle2(4'h1);
    ticks(2);
    @(negedge clk);
    total++;
    if (pause2 !== 1'b1) $display("FAIL b2b_pause: got %b expected 1", pause2); else passed++;
    settle2(4'h0);
    ticks(2);
    settle2(4'h2);
    ticks(2);
    settle2(4'h0);
    ticks(2);
    settle2(4'h2);
    ticks(2);
    total++;
    if (prs2[1] !== 1'b1 || step2 !== 1'b1)
      $display("FAIL b2b_second_press: got prs=%b step=%b expected 1/1", prs2[1], step2);
    else passed++;
    repeat (30) @(negedge clk);
    total++;
    if (s2 - bs != 16 || q1 - bq != 2)
      $display("FAIL b2b_width: got high=%0d presses=%0d expected 16/2", s2 - bs, q1 - bq);
    else passed++;
  endtask
  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_pause_toggle();
    test_step();
    test_simultaneous();
    test_reset_mid_step();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
